// File: rtl/fifo_bank_if.sv
// Purpose : shared-data / per-FIFO-cke bus between the routing matrix tx side and a FIFO bank, plus show-ahead read ports.
// Latency : n/a (signal bundle only).
// Backpressure: full/ovf report drops back to the matrix; rdy/pop are the consumer-side valid/ready pair per FIFO.
//
// Signals: data (shared write word), cke (per-FIFO push), pop (per-FIFO read strobe),
//          full/rdy/ovf (per-FIFO flags), q (packed head words, FIFO i at [(i+1)*O-1:i*O]),
//          level (per-FIFO word count, only when FIFO_BANK_LEVEL_EN is defined).
// Modports: master = matrix + consumers driving the bank, slave = the bank itself.
interface fifo_bank_if #(
    parameter int N = 8,    // number of FIFOs
    parameter int O = 8,    // data width
    parameter int D = 16    // depth per FIFO
);
    logic [O-1:0]   data;
    logic [N-1:0]   cke;
    logic [N-1:0]   pop;
    logic [N-1:0]   full;
    logic [N-1:0]   rdy;
    logic [N-1:0]   ovf;
    logic [N*O-1:0] q;
`ifdef FIFO_BANK_LEVEL_EN
    logic [N*($clog2(D)+1)-1:0] level;
`endif

    modport master (
        output data, cke, pop,
        input  full, rdy, ovf, q
`ifdef FIFO_BANK_LEVEL_EN
        , input level
`endif
    );

    modport slave (
        input  data, cke, pop,
        output full, rdy, ovf, q
`ifdef FIFO_BANK_LEVEL_EN
        , output level
`endif
    );
endinterface

// File: rtl/fifo_bank.sv
// Purpose : bank of N independent show-ahead FIFOs fed from one shared write bus with per-FIFO push enables.
// Latency : 1 cycle write-to-read; head word is visible on q as soon as rdy is high.
// Backpressure: pushes to a full FIFO are dropped and latch the sticky ovf bit; a same-cycle pop makes room.
//
// Ports: clk, rst (synchronous, active-high), bus (fifo_bank_if.slave: data, cke, pop in;
//        full, rdy, ovf, q out).
// Optional: define FIFO_BANK_LEVEL_EN to add bus.level, the per-FIFO word count (0..D).
module fifo_bank #(
    parameter int N = 8,    // number of FIFOs (1..32)
    parameter int O = 8,    // data width in bits
    parameter int D = 16    // depth in words, power of two, >= 2
) (
    input  logic         clk,
    input  logic         rst,
    fifo_bank_if.slave   bus
);
    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;

    logic [AW-1:0] wrptr_q [N];
    logic [AW-1:0] wrptr_d [N];
    logic [AW-1:0] rdptr_q [N];
    logic [AW-1:0] rdptr_d [N];
    logic [CW-1:0] cnt_q   [N];
    logic [CW-1:0] cnt_d   [N];
    logic [N-1:0]  ovf_q;
    logic [N-1:0]  ovf_d;

    logic [N-1:0]  full_w;
    logic [N-1:0]  rdy_w;
    logic [N-1:0]  pop_ok;
    logic [N-1:0]  push_ok;

    // Storage is not reset; only pointers and count define what is valid.
    logic [O-1:0]  mem_q [N][D];

    // Next-state: flags come from the registered count, so they only move after an edge.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            full_w[i]  = (cnt_q[i] == CW'(D));
            rdy_w[i]   = (cnt_q[i] != '0);
            pop_ok[i]  = bus.pop[i] & rdy_w[i];
            // A pop in the same cycle frees the slot a full FIFO needs for the push.
            push_ok[i] = bus.cke[i] & (~full_w[i] | pop_ok[i]);
            // Pointers are exactly AW bits, so D-1 -> 0 wrap is the natural overflow.
            wrptr_d[i] = wrptr_q[i] + AW'(push_ok[i]);
            rdptr_d[i] = rdptr_q[i] + AW'(pop_ok[i]);
            cnt_d[i]   = cnt_q[i] + CW'(push_ok[i]) - CW'(pop_ok[i]);
            ovf_d[i]   = ovf_q[i] | (bus.cke[i] & full_w[i] & ~pop_ok[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                wrptr_q[i] <= '0;
                rdptr_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                wrptr_q[i] <= wrptr_d[i];
                rdptr_q[i] <= rdptr_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    // A write during reset lands in storage but is discarded by the pointer reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push_ok[i]) begin
                mem_q[i][wrptr_q[i]] <= bus.data;
            end
        end
    end

    // Show-ahead read: head word is always the location at rdptr.
    always_comb begin
        bus.q = '0;
        for (int i = 0; i < N; i++) begin
            bus.q[i*O +: O] = mem_q[i][rdptr_q[i]];
        end
    end

    assign bus.full = full_w;
    assign bus.rdy  = rdy_w;
    assign bus.ovf  = ovf_q;

`ifdef FIFO_BANK_LEVEL_EN
    always_comb begin
        bus.level = '0;
        for (int i = 0; i < N; i++) begin
            bus.level[i*CW +: CW] = cnt_q[i];
        end
    end
`endif
endmodule

// File: doc/fifo_bank.md
Name: fifo_bank

Overview:
- Bank of n independent synchronous FIFOs sharing one write-data bus, with one write clock-enable per FIFO.
- Receiving end of the shared-data/per-FIFO-cke interface driven by the routing matrix: a frame on data is stored into every FIFO whose cke bit is set in that cycle.
- Each FIFO exposes a show-ahead read port (head data, ready flag, pop input) for UART transmitters or other consumers.
- Sits between the matrix tx side and the TX peripherals.

Parameters:
- n, 8, number of FIFOs (1..32)
- o, 8, data width in bits
- d, 16, depth of each FIFO in words; power of two, minimum 2

Ports:
- clk  input  1  master clock
- rst  input  1  synchronous reset, active-high
- data  input  o  shared write data, common to all FIFOs
- cke  input  n  per-FIFO write enable; bit i pushes data into FIFO i
- full  output  n  bit i high when FIFO i holds d words
- q  output  n*o  head word of FIFO i on bits [(i+1)*o-1 : i*o]
- rdy  output  n  bit i high when FIFO i is non-empty (q slice valid)
- pop  input  n  bit i removes the head word of FIFO i
- ovf  output  n  sticky overflow flag; bit i set when a push to full FIFO i was dropped

Behaviour:
- Per FIFO: d-word storage, write pointer and read pointer of $clog2(d) bits, plus a count of $clog2(d)+1 bits. Pointers wrap from d-1 to 0.
- Reset (rst high at a clk edge): all pointers and counts = 0; full = 0; rdy = 0; ovf = 0. Storage contents are not cleared, and q is don't-care while rdy = 0. Reset overrides cke and pop in the same cycle. Reset mid-stream discards all stored words.
- Push: cke[i]=1 at edge k and FIFO i not full (flags as sampled before edge k):
  - data is written at wrptr, and wrptr increments.
  - rdy[i] rises after edge k if the FIFO was empty.
  - Write-to-read latency is 1 cycle.
- Pop: pop[i]=1 at edge k and rdy[i]=1:
  - rdptr increments.
  - The new head appears on q after edge k.
  - pop[i] while rdy[i]=0 is ignored: no pointer change, no flag.
- q slice i is driven from storage at rdptr (show-ahead). It is stable while no pop occurs, including during pushes to non-head locations.
- Simultaneous push and pop on the same FIFO:
  - Not empty and not full: both are performed; count is unchanged.
  - Full: the pop frees a slot and the push is accepted; full stays 1, ovf is not set.
  - Empty: the pop is ignored and the push is accepted; count goes to 1.
- Overflow: cke[i]=1 while full[i]=1 and no valid pop. The word is dropped, pointers are unchanged, and ovf[i] is set. ovf[i] is cleared only by rst.
- Flag derivation:
  - full[i] = (count == d).
  - rdy[i] = (count != 0).
  - Both are registered, or derived combinationally from registered count; either way they change only after a clk edge.
- FIFOs are fully independent. Any cke/pop pattern across FIFOs, including all bits high, is legal in a single cycle.

Optional Feature:
- Macro FIFO_BANK_LEVEL_EN.
- Defined: adds output port level, width n*($clog2(d)+1). The slice for FIFO i carries its current count (0..d), updated on the same edge as the pointers, and reset to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then cke=0 and pop=0 -> full=0, rdy=0, ovf=0 on all FIFOs.
- Broadcast: data=0xA5 with cke=8'b1000_0101 for one cycle -> next cycle rdy=8'b1000_0101. q slices 0, 2 and 7 = 0xA5. Pop those three -> rdy=0 on the following cycle.
- Order and wrap: push 0x00..0x1F into FIFO 3 (d=16), interleaving 20 pops -> pops return strictly incrementing values across pointer wrap. Words beyond capacity are dropped and set ovf[3], and only when the FIFO was full.
- Full boundary: fill FIFO 0 with 16 words -> full[0]=1. Then push 0x77 together with pop in the same cycle -> full[0] stays 1, ovf[0]=0, and the last word popped later is 0x77.
- Overflow/empty edges: push to full FIFO 1 without pop -> ovf[1]=1, count stays 16. Pop an empty FIFO 2 -> no change. Then assert rst mid-stream -> all flags 0, ovf cleared.
- With FIFO_BANK_LEVEL_EN: 5 pushes and 2 pops on FIFO 4 -> level slice 4 reads 3; after rst it reads 0.
